// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// regfile_ctrl_pkg : shared widths and FSM encoding for the writeback control
// Revision 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Register 0 is never cleared, so the sweep starts at 1.
  localparam logic [ADDR_W-1:0] CLR_FIRST = 5'd1;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (addr == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-requester round-robin arbiter with a 1-bit favoured pointer
// Revision 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // After a grant the other requester becomes favoured.
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// regfile_wb_ctrl : clears the register file after reset, then arbitrates
// ALU/load writebacks onto a single registered write port.
// Revision 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              v0,
  input  logic [ADDR_W-1:0] a0,
  input  logic [DATA_W-1:0] d0,
  output logic              rdy0,
  input  logic              v1,
  input  logic [ADDR_W-1:0] a1,
  input  logic [DATA_W-1:0] d1,
  output logic              rdy1,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              busy,
  output logic              gnt_id
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] wa3_q, wa3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              gnt_id_q, gnt_id_d;
  logic [1:0]        gnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({v1, v0}),
    .en    (state_q == RUN),
    .gnt   (gnt)
  );

  assign rdy0   = gnt[0];
  assign rdy1   = gnt[1];
  assign busy   = (state_q == CLEAR);
  assign we3    = we3_q;
  assign wa3    = wa3_q;
  assign wd3    = wd3_q;
  assign gnt_id = gnt_id_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    gnt_id_d = gnt_id_q;
    if (state_q == CLEAR) begin
      // The counter wraps to 0 after issuing register 31; that cycle is the
      // last CLEAR cycle and issues nothing.
      if (cnt_q != '0) begin
        we3_d = 1'b1;
        wa3_d = cnt_q;
        wd3_d = '0;
        cnt_d = cnt_q + 5'd1;
      end else begin
        state_d = RUN;
        cnt_d   = CLR_FIRST;
      end
    end else begin
      if (gnt[0]) begin
        we3_d    = ~is_zero_reg(a0);
        wa3_d    = a0;
        wd3_d    = d0;
        gnt_id_d = 1'b0;
      end else if (gnt[1]) begin
        we3_d    = ~is_zero_reg(a1);
        wa3_d    = a1;
        wd3_d    = d1;
        gnt_id_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q    <= CLR_FIRST;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      gnt_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      gnt_id_q <= gnt_id_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_ctrl : directed bench with a cycle scoreboard and bench regfile
// Revision 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;
  import regfile_ctrl_pkg::*;

  localparam bit CLR = 1'b1;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        id;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        rdy0, rdy1, we3, busy, gnt_id;
  logic [4:0]  wa3;
  logic [31:0] wd3;

  logic [31:0] mem [32];

  int     n_total = 0;
  int     n_pass  = 0;
  wr_t    sb[$];
  wr_t    m_last;
  logic   m_valid = 1'b0;
  state_e m_state;
  logic [4:0] m_cnt;
  logic   m_ptr;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.CLEAR_ON_RESET(CLR)) dut (
    .clk(clk), .reset(reset),
    .v0(v0), .a0(a0), .d0(d0), .rdy0(rdy0),
    .v1(v1), .a1(a1), .d1(d1), .rdy1(rdy1),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .busy(busy), .gnt_id(gnt_id)
  );

  always @(posedge clk) begin
    if (we3 === 1'b1) mem[wa3] <= wd3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: check this cycle at negedge, predict the next, end at posedge+1.
  task automatic step();
    wr_t  e;
    logic g0, g1;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    e  = m_last;
    if (m_valid && m_state == RUN) begin
      g0 = v0 && (!v1 || !m_ptr);
      g1 = v1 && (!v0 || m_ptr);
    end
    if (m_valid) begin
      chk("busy", busy, m_state == CLEAR);
      if (!reset) begin
        chk("rdy0", rdy0, g0);
        chk("rdy1", rdy1, g1);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("we3", we3, e.we);
        chk("wa3", wa3, e.wa);
        chk("wd3", wd3, e.wd);
        chk("gnt_id", gnt_id, e.id);
      end
    end
    e = m_last;
    e.we = 1'b0;
    if (reset) begin
      m_valid = 1'b1;
      m_state = CLR ? CLEAR : RUN;
      m_cnt   = 5'd1;
      m_ptr   = 1'b0;
      e       = '0;
      sb.delete();
    end else if (m_state == CLEAR) begin
      if (m_cnt != 5'd0) begin
        e.we = 1'b1;
        e.wa = m_cnt;
        e.wd = 32'd0;
        m_cnt = m_cnt + 5'd1;
      end else begin
        m_state = RUN;
        m_cnt   = 5'd1;
      end
    end else begin
      if (g0) begin
        e.we = (a0 != 5'd0); e.wa = a0; e.wd = d0; e.id = 1'b0;
      end else if (g1) begin
        e.we = (a1 != 5'd0); e.wa = a1; e.wd = d1; e.id = 1'b1;
      end
      if (g0 || g1) m_ptr = g0;
    end
    if (m_valid) begin
      sb.push_back(e);
      m_last = e;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       found;
    int         nclr;
    logic [4:0] first;
    m_last = '0;
    reset = 1'b1;
    v0 = 1'b0; a0 = '0; d0 = '0;
    v1 = 1'b0; a1 = '0; d1 = '0;
    mem[0] = 32'd0;

    // Reset and full clear sweep.
    step();
    reset = 1'b0;
    repeat (34) step();
    for (int i = 1; i < 32; i++) chk("clr_mem", mem[i], 32'd0);

    // Single requester 0.
    v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
    step();
    v0 = 1'b0;
    step();
    chk("rd_r5", mem[5], 32'hDEADBEEF);

    // Write to register 0 from requester 1; leaves pointer at 0.
    mem[0] = 32'd0;
    v1 = 1'b1; a1 = 5'd0; d1 = 32'hFFFFFFFF;
    step();
    v1 = 1'b0;
    step();
    chk("rd_r0", mem[0], 32'd0);

    // Round-robin with both requesters held valid.
    v0 = 1'b1; a0 = 5'd3; d0 = 32'd1;
    v1 = 1'b1; a1 = 5'd4; d1 = 32'd2;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k % 2 == 0) d0 = d0 + 32'd1;
      else            d1 = d1 + 32'd1;
    end
    v0 = 1'b0; v1 = 1'b0;
    step();
    chk("rd_r3", mem[3], 32'd2);
    chk("rd_r4", mem[4], 32'd3);

    // Move pointer to 1, then same-address conflict.
    v0 = 1'b1; a0 = 5'd9; d0 = 32'd3;
    step();
    a0 = 5'd7; d0 = 32'd11;
    v1 = 1'b1; a1 = 5'd7; d1 = 32'd22;
    step();
    v1 = 1'b0;
    step();
    v0 = 1'b0;
    step();
    step();
    chk("rd_r7", mem[7], 32'd11);

    // Reset in RUN while a write is being accepted.
    v0 = 1'b1; a0 = 5'd12; d0 = 32'd55;
    reset = 1'b1;
    step();
    reset = 1'b0;
    v0 = 1'b0;
    chk("rst_run_we3", we3, 1'b0);

    // Reset mid-clear at register 17.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (we3 === 1'b1 && wa3 == 5'd17) found = 1'b1;
    end
    chk("seen_wa17", found, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    nclr  = 0;
    first = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (we3 === 1'b1) begin
        if (nclr == 0) first = wa3;
        nclr++;
      end
    end
    chk("reclr_count", nclr, 31);
    chk("reclr_first", first, 5'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
